// File: rtl/alu_seq.sv
// Registered ALU: single-cycle arithmetic/logic/compare ops, plus iterative
// shifts and rotates that move one bit per clock, with C/Z/S flag registers.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       operation,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             C,
  output logic             Z,
  output logic             S
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [4:0] {
    OP_ADD = 5'b00000, OP_SUB = 5'b00001, OP_ADC = 5'b00010, OP_SBC = 5'b00011,
    OP_AND = 5'b00100, OP_OR  = 5'b00101, OP_NOT = 5'b00110, OP_XOR = 5'b00111,
    OP_INC = 5'b01000, OP_DEC = 5'b01001, OP_CMP = 5'b01010, OP_TST = 5'b01011,
    OP_SHL = 5'b10000, OP_SHR = 5'b10001, OP_SAL = 5'b10010, OP_SAR = 5'b10011,
    OP_ROL = 5'b10100, OP_ROR = 5'b10101, OP_RCL = 5'b10110, OP_RCR = 5'b10111
  } op_e;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state, state_n;
  logic [WIDTH-1:0] work, work_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             carry, carry_n;
  logic [2:0]       sop, sop_n;
  logic [WIDTH-1:0] result_n;
  logic             c_n, z_n, s_n, done_n;

  logic [WIDTH:0]   arith;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH-1:0] step_work;
  logic             step_bit;
  logic [CW-1:0]    count;

  assign count = B[CW-1:0];
  assign busy  = (state == SHIFT);

  // Arithmetic at WIDTH+1 bits so the top bit is carry out / borrow.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    arith = '0;
    case (operation)
      OP_ADD:         arith = {1'b0, A} + {1'b0, B};
      OP_SUB, OP_CMP: arith = {1'b0, A} - {1'b0, B};
      OP_ADC:         arith = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C};
      OP_SBC:         arith = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, C};
      OP_INC:         arith = {1'b0, B} + (WIDTH+1)'(1);
      OP_DEC:         arith = {1'b0, B} - (WIDTH+1)'(1);
      default:        arith = '0;
    endcase
  end

  always_comb begin
    logic_res = '0;
    case (operation)
      OP_AND, OP_TST: logic_res = A & B;
      OP_OR:          logic_res = A | B;
      OP_XOR:         logic_res = A ^ B;
      OP_NOT:         logic_res = ~A;
      default:        logic_res = '0;
    endcase
  end

  // One shift/rotate step; RCL/RCR treat {carry, work} as a WIDTH+1 ring.
  always_comb begin
    step_work = work;
    step_bit  = 1'b0;
    case (sop)
      3'b000, 3'b010: begin step_bit = work[WIDTH-1]; step_work = {work[WIDTH-2:0], 1'b0}; end
      3'b001: begin step_bit = work[0]; step_work = {1'b0, work[WIDTH-1:1]}; end
      3'b011: begin step_bit = work[0]; step_work = {work[WIDTH-1], work[WIDTH-1:1]}; end
      3'b100: begin step_bit = work[WIDTH-1]; step_work = {work[WIDTH-2:0], work[WIDTH-1]}; end
      3'b101: begin step_bit = work[0]; step_work = {work[0], work[WIDTH-1:1]}; end
      3'b110: begin step_bit = work[WIDTH-1]; step_work = {work[WIDTH-2:0], carry}; end
      3'b111: begin step_bit = work[0]; step_work = {carry, work[WIDTH-1:1]}; end
      default: begin step_bit = 1'b0; step_work = work; end
    endcase
  end

  always_comb begin
    state_n  = state;
    work_n   = work;
    cnt_n    = cnt;
    carry_n  = carry;
    sop_n    = sop;
    result_n = result;
    c_n      = C;
    z_n      = Z;
    s_n      = S;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          done_n = 1'b1;
          case (operation)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
              result_n = arith[WIDTH-1:0];
              c_n      = arith[WIDTH];
              z_n      = ~|arith[WIDTH-1:0];
              s_n      = arith[WIDTH-1];
            end
            OP_CMP: begin
              c_n = arith[WIDTH];
              z_n = ~|arith[WIDTH-1:0];
              s_n = arith[WIDTH-1];
            end
            OP_INC, OP_DEC: begin
              result_n = arith[WIDTH-1:0];
              z_n      = ~|arith[WIDTH-1:0];
              s_n      = arith[WIDTH-1];
            end
            OP_AND, OP_OR, OP_NOT, OP_XOR: begin
              result_n = logic_res;
              c_n      = 1'b0;
              z_n      = ~|logic_res;
              s_n      = logic_res[WIDTH-1];
            end
            OP_TST: begin
              c_n = 1'b0;
              z_n = ~|logic_res;
              s_n = logic_res[WIDTH-1];
            end
            OP_SHL, OP_SHR, OP_SAL, OP_SAR, OP_ROL, OP_ROR, OP_RCL, OP_RCR: begin
              if (count == '0) begin
                result_n = A;
                z_n      = ~|A;
                s_n      = A[WIDTH-1];
              end else begin
                done_n  = 1'b0;
                state_n = SHIFT;
                work_n  = A;
                cnt_n   = count;
                carry_n = C;
                sop_n   = operation[2:0];
              end
            end
            default: ;  // undefined opcode: only done pulses
          endcase
        end
      end
      SHIFT: begin
        work_n  = step_work;
        carry_n = step_bit;
        cnt_n   = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result_n = step_work;
          c_n      = step_bit;
          z_n      = ~|step_work;
          s_n      = step_work[WIDTH-1];
          done_n   = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sop    <= '0;
      result <= '0;
      C      <= 1'b0;
      Z      <= 1'b0;
      S      <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      work   <= work_n;
      cnt    <= cnt_n;
      carry  <= carry_n;
      sop    <= sop_n;
      result <= result_n;
      C      <= c_n;
      Z      <= z_n;
      S      <= s_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table run back-to-back on an 8-bit
// instance, hand sequences for busy/abort corners, and a 16-bit instance.
module tb_alu_seq;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, ADC = 5'b00010, SBC = 5'b00011;
  localparam logic [4:0] AND = 5'b00100, OR  = 5'b00101, NOT = 5'b00110, XOR = 5'b00111;
  localparam logic [4:0] INC = 5'b01000, DEC = 5'b01001, CMP = 5'b01010, TST = 5'b01011;
  localparam logic [4:0] SHL = 5'b10000, SHR = 5'b10001, SAL = 5'b10010, SAR = 5'b10011;
  localparam logic [4:0] ROL = 5'b10100, ROR = 5'b10101, RCL = 5'b10110, RCR = 5'b10111;
  localparam logic [4:0] UND = 5'b01100;
  localparam int MAX_WAIT = 40;

  typedef struct {
    logic [4:0] op;
    logic [7:0] a, b, res;
    logic       c, z, s;
    int         lat;
  } vec_t;

  logic        clk, reset;
  logic        start, busy, done, c8, z8, s8;
  logic [7:0]  a8, b8, result8;
  logic [4:0]  op8;
  logic        start16, busy16, done16, c16, z16, s16;
  logic [15:0] a16, b16, result16;
  logic [4:0]  op16;

  int n_checks = 0;
  int n_err    = 0;

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .A(a8), .B(b8), .operation(op8),
    .busy(busy), .done(done), .result(result8), .C(c8), .Z(z8), .S(s8)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .A(a16), .B(b16), .operation(op16),
    .busy(busy16), .done(done16), .result(result16), .C(c16), .Z(z16), .S(s16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start an op, scramble inputs after acceptance, count edges until done.
  task automatic run_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
    @(negedge clk);
    start = 1'b1; op8 = op; a8 = a; b8 = b;
    @(posedge clk); #1;
    start = 1'b0; op8 = 5'b11111; a8 = ~a; b8 = ~b;
    lat = 1;
    while (!done && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          output int lat);
    @(negedge clk);
    start16 = 1'b1; op16 = op; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; op16 = 5'b11111; a16 = ~a; b16 = ~b;
    lat = 1;
    while (!done16 && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  vec_t vecs[23];

  initial begin
    int lat;

    vecs[0]  = '{SUB, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b1, 1};
    vecs[1]  = '{SBC, 8'h10, 8'h01, 8'h0E, 1'b0, 1'b0, 1'b0, 1};
    vecs[2]  = '{CMP, 8'h07, 8'h07, 8'h0E, 1'b0, 1'b1, 1'b0, 1};
    vecs[3]  = '{ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[4]  = '{ADC, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{ADD, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1};
    vecs[6]  = '{OR,  8'h80, 8'h01, 8'h81, 1'b0, 1'b0, 1'b1, 1};
    vecs[7]  = '{NOT, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    vecs[8]  = '{XOR, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1, 1};
    vecs[9]  = '{AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1};
    vecs[10] = '{SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1};
    vecs[11] = '{INC, 8'h00, 8'h7F, 8'h80, 1'b1, 1'b0, 1'b1, 1};
    vecs[12] = '{DEC, 8'h00, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0, 1};
    vecs[13] = '{TST, 8'hF0, 8'h0F, 8'h01, 1'b0, 1'b1, 1'b0, 1};
    vecs[14] = '{UND, 8'h12, 8'h34, 8'h01, 1'b0, 1'b1, 1'b0, 1};
    vecs[15] = '{SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1, 1};
    vecs[16] = '{RCR, 8'h01, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 2};
    vecs[17] = '{SAR, 8'h80, 8'h07, 8'hFF, 1'b0, 1'b0, 1'b1, 8};
    vecs[18] = '{SHR, 8'h03, 8'h09, 8'h01, 1'b1, 1'b0, 1'b0, 2};
    vecs[19] = '{SAL, 8'h55, 8'h00, 8'h55, 1'b1, 1'b0, 1'b0, 1};
    vecs[20] = '{SHL, 8'hC0, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0, 3};
    vecs[21] = '{RCL, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 2};
    vecs[22] = '{ROR, 8'h01, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 2};

    reset = 1'b1;
    start = 1'b0; op8 = ADD; a8 = '0; b8 = '0;
    start16 = 1'b0; op16 = ADD; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result8, 0);
    check("reset flags", {c8, z8, s8}, 0);
    @(negedge clk);
    reset = 1'b0;

    // 16-bit instance
    run_op16(ADD, 16'hFFFF, 16'h0001, lat);
    check("w16 add latency", lat, 1);
    check("w16 add result", result16, 16'h0000);
    check("w16 add flags", {c16, z16, s16}, 3'b110);
    run_op16(ROL, 16'h8000, 16'h000F, lat);
    check("w16 rol latency", lat, 16);
    check("w16 rol result", result16, 16'h4000);
    check("w16 rol flags", {c16, z16, s16}, 3'b000);

    // First ADD: done for exactly one cycle, busy never set
    run_op(ADD, 8'hF0, 8'h20, lat);
    check("add latency", lat, 1);
    check("add busy", busy, 0);
    check("add result", result8, 8'h10);
    check("add flags", {c8, z8, s8}, 3'b100);
    @(posedge clk); #1;
    check("add done falls", done, 0);
    check("add busy after", busy, 0);

    // Table, issued back-to-back in each done cycle
    for (int i = 0; i < 23; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d result", i), result8, vecs[i].res);
      check($sformatf("vec%0d C", i), c8, vecs[i].c);
      check($sformatf("vec%0d Z", i), z8, vecs[i].z);
      check($sformatf("vec%0d S", i), s8, vecs[i].s);
    end

    // ROL 0x81 by 3 with a stray start while busy
    @(negedge clk);
    start = 1'b1; op8 = ROL; a8 = 8'h81; b8 = 8'h03;
    @(posedge clk); #1;
    start = 1'b0;
    check("rol busy e0", {busy, done}, 2'b10);
    @(negedge clk);
    start = 1'b1; op8 = ADD; a8 = 8'h01; b8 = 8'h01;
    @(posedge clk); #1;
    start = 1'b0;
    check("rol busy e1", {busy, done}, 2'b10);
    @(posedge clk); #1;
    check("rol busy e2", {busy, done}, 2'b10);
    check("rol result held", result8, 8'h80);
    @(posedge clk); #1;
    check("rol done", {busy, done}, 2'b01);
    check("rol result", result8, 8'h0C);
    check("rol flags", {c8, z8, s8}, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rol no extra done %0d", i), {busy, done}, 2'b00);
    end
    check("rol result kept", result8, 8'h0C);

    // ROR 0x0F by 5 aborted by reset after step 2
    @(negedge clk);
    start = 1'b1; op8 = ROR; a8 = 8'h0F; b8 = 8'h05;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort step%0d", i + 1), {busy, done}, 2'b10);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort busy done", {busy, done}, 2'b00);
    check("abort result", result8, 0);
    check("abort flags", {c8, z8, s8}, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("abort no done %0d", i), {busy, done}, 2'b00);
    end
    run_op(ADD, 8'h01, 8'h01, lat);
    check("post-abort latency", lat, 1);
    check("post-abort result", result8, 8'h02);
    check("post-abort flags", {c8, z8, s8}, 3'b000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
